// File: rtl/clock_gate_pkg.sv
// -----------------------------------------------------------------------------
// clock_gate_pkg
// Shared types and defaults for the clock-gate enable controller.
//   cg_state_e     : FSM state (RUN=0, OFF=1, WAKE=2; encoding 3 unused)
//   DEF_CNT_W      : default idle counter / idle_limit width
//   DEF_WAKE_CYC   : default number of WAKE cycles before clk_ready
//   DEF_STAT_W     : default width of the gated-cycle statistic
//   state_enable() : gating-cell enable implied by a state
//   state_ready()  : clk_ready implied by a state
// -----------------------------------------------------------------------------
package clock_gate_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_WAKE_CYC = 2;
  localparam int DEF_STAT_W   = 16;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } cg_state_e;

  // The clock runs in every state except OFF.
  function automatic logic state_enable(input cg_state_e st);
    return (st != ST_OFF);
  endfunction

  // The gated clock is only trusted once WAKE has completed.
  function automatic logic state_ready(input cg_state_e st);
    return (st == ST_RUN);
  endfunction

endpackage

// File: rtl/cg_idle_counter.sv
// -----------------------------------------------------------------------------
// cg_idle_counter
// Saturating count of consecutive idle cycles with a live limit compare.
// Ports:
//   clk, reset : free-running clock, synchronous active-high reset
//   clr        : force the count to 0 (non-idle cycle, or not in RUN)
//   inc        : count this idle cycle
//   limit      : idle_limit, compared every cycle; 0 disables hit
//   hit        : this increment reaches (or passes) a non-zero limit
// -----------------------------------------------------------------------------
module cg_idle_counter
  import clock_gate_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W:0]   count_plus_s;
  logic             at_limit_s;

  // One extra bit so the increment never wraps before the compare.
  assign count_plus_s = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};
  // ">=" rather than "==" so a limit lowered below the count still trips.
  assign at_limit_s   = (count_plus_s >= {1'b0, limit});
  assign hit          = inc && at_limit_s && (limit != {CNT_W{1'b0}});

  // Idle count register. Reaching the limit either sleeps (count restarts at 0)
  // or, with limit 0, saturates at the limit which is also 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      if (at_limit_s) begin
        count_r <= {CNT_W{1'b0}};
      end else begin
        count_r <= count_plus_s[CNT_W-1:0];
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clock_gate_ctrl
// Idle-detect controller producing the enable of the clock-gating cell.
// Drops enable after idle_limit consecutive idle cycles, re-raises it on
// activity/force_on and signals clk_ready after WAKE_CYC settle cycles.
// Optional feature macro: CG_STATS_EN (adds the gated_cycles counter/port).
// Ports:
//   clk, reset    : free-running clock, synchronous active-high reset
//   activity      : gated-domain work pending
//   force_on      : keep the clock running (acts like activity)
//   idle_limit    : idle cycles before gating, 0 disables gating
//   enable        : registered gating-cell enable
//   clk_ready     : registered, gated clock stable and running
//   state         : current FSM state (debug)
//   gated_cycles  : saturating count of enable=0 cycles (CG_STATS_EN only)
// -----------------------------------------------------------------------------
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WAKE_CYC = DEF_WAKE_CYC,
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activity,
  input  logic             force_on,
  input  logic [CNT_W-1:0] idle_limit,
  output logic             enable,
  output logic             clk_ready,
  output logic [1:0]       state
`ifdef CG_STATS_EN
  ,
  output logic [STAT_W-1:0] gated_cycles
`endif
);

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC);

  logic [1:0] state_r;
  cg_state_e  next_state_s;
  logic [3:0] wake_cnt_r;
  logic [3:0] wake_nxt_s;
  logic       enable_r;
  logic       clk_ready_r;
  logic       idle_s;
  logic       cnt_inc_s;
  logic       cnt_clr_s;
  logic       hit_s;

  assign idle_s    = !activity && !force_on;
  // Counting only happens in RUN; every other state keeps the count at 0,
  // which also restarts it on re-entry to RUN.
  assign cnt_inc_s = (state_r == ST_RUN) && idle_s;
  assign cnt_clr_s = !cnt_inc_s;

  cg_idle_counter #(
    .CNT_W (CNT_W)
  ) u_idle_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .limit (idle_limit),
    .hit   (hit_s)
  );

  // Next-state and wake-counter logic.
  always_comb begin
    next_state_s = ST_RUN;
    wake_nxt_s   = 4'd0;
    case (state_r)
      ST_RUN: begin
        // hit_s is only ever set on an idle cycle, so activity on the
        // threshold cycle keeps us in RUN.
        if (hit_s) begin
          next_state_s = ST_OFF;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_OFF: begin
        if (idle_s) begin
          next_state_s = ST_OFF;
        end else begin
          next_state_s = ST_WAKE;
          wake_nxt_s   = 4'd1;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_r >= WAKE_LAST) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_WAKE;
          wake_nxt_s   = wake_cnt_r + 4'd1;
        end
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // State, wake counter and outputs; outputs are decoded from the next state
  // so they are plain flops aligned with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      wake_cnt_r  <= 4'd0;
      enable_r    <= 1'b1;
      clk_ready_r <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      wake_cnt_r  <= wake_nxt_s;
      enable_r    <= state_enable(next_state_s);
      clk_ready_r <= state_ready(next_state_s);
    end
  end

  assign enable    = enable_r;
  assign clk_ready = clk_ready_r;
  assign state     = state_r;

`ifdef CG_STATS_EN
  logic [STAT_W-1:0] gated_cnt_r;

  // Saturating count of cycles spent with the registered enable low.
  always_ff @(posedge clk) begin
    if (reset) begin
      gated_cnt_r <= {STAT_W{1'b0}};
    end else if (!enable_r && (gated_cnt_r != {STAT_W{1'b1}})) begin
      gated_cnt_r <= gated_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      gated_cnt_r <= gated_cnt_r;
    end
  end

  assign gated_cycles = gated_cnt_r;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_gate_ctrl
// Scoreboard bench: the driver applies inputs on the falling edge, steps a
// behavioural model and queues the outputs expected after the next rising
// edge; an independent monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_clock_gate_ctrl;

  localparam int CNT_W    = 8;
  localparam int WAKE_CYC = 2;
  localparam int STAT_W   = 3;
  localparam int GATED_MAX = (1 << STAT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             activity = 1'b1;
  logic             force_on = 1'b0;
  logic [CNT_W-1:0] idle_limit = 8'd4;
  logic             enable;
  logic             clk_ready;
  logic [1:0]       state;
`ifdef CG_STATS_EN
  logic [STAT_W-1:0] gated_cycles;
`endif

  clock_gate_ctrl #(
    .CNT_W    (CNT_W),
    .WAKE_CYC (WAKE_CYC),
    .STAT_W   (STAT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .activity   (activity),
    .force_on   (force_on),
    .idle_limit (idle_limit),
    .enable     (enable),
    .clk_ready  (clk_ready),
    .state      (state)
`ifdef CG_STATS_EN
    ,
    .gated_cycles (gated_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic rdy;
    int   st;
    int   gc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: mode 0=RUN 1=OFF 2=WAKE, idle run length,
  // remaining wake cycles, cycles spent gated.
  int m_mode  = 0;
  int m_run   = 0;
  int m_wake  = 0;
  int m_gated = 0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, want, $time);
    end
  endfunction

  function automatic void model_step(logic r, logic a, logic f, int lim);
    bit idle;
    if (r) begin
      m_mode = 0; m_run = 0; m_wake = 0; m_gated = 0;
      return;
    end
    if (m_mode == 1 && m_gated < GATED_MAX) m_gated++;
    idle = !a && !f;
    case (m_mode)
      0: begin
        if (idle) begin
          m_run++;
          if (lim != 0 && m_run >= lim) begin
            m_mode = 1;
            m_run  = 0;
          end else if (m_run > lim) begin
            m_run = lim;
          end
        end else begin
          m_run = 0;
        end
      end
      1: begin
        if (!idle) begin
          m_mode = 2;
          m_wake = WAKE_CYC;
        end
      end
      default: begin
        m_wake--;
        if (m_wake == 0) begin
          m_mode = 0;
          m_run  = 0;
        end
      end
    endcase
  endfunction

  task automatic cycle(input logic r, input logic a, input logic f, input logic [CNT_W-1:0] l);
    exp_t e;
    @(negedge clk);
    reset = r; activity = a; force_on = f; idle_limit = l;
    model_step(r, a, f, int'(l));
    e.en  = (m_mode != 1);
    e.rdy = (m_mode == 0);
    e.st  = m_mode;
    e.gc  = m_gated;
    exp_q.push_back(e);
  endtask

  task automatic repeat_cycle(input int n, input logic a, input logic f, input logic [CNT_W-1:0] l);
    for (int i = 0; i < n; i++) cycle(1'b0, a, f, l);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("enable", {31'd0, enable}, {31'd0, e.en});
        check("clk_ready", {31'd0, clk_ready}, {31'd0, e.rdy});
        check("state", {30'd0, state}, e.st);
`ifdef CG_STATS_EN
        check("gated_cycles", {29'd0, gated_cycles}, e.gc);
`endif
      end
    end
  end

  initial begin
    logic             r, a, f;
    logic [CNT_W-1:0] lim;
    // Reset held 3 cycles with activity high.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 8'd4);
    // Busy, then idle run reaching the limit of 4, then stay gated.
    repeat_cycle(10, 1'b1, 1'b0, 8'd4);
    repeat_cycle(8, 1'b0, 1'b0, 8'd4);
    // Wake, then stay busy through WAKE and into RUN.
    repeat_cycle(5, 1'b1, 1'b0, 8'd4);
    // Idle run broken one cycle before the threshold.
    repeat_cycle(3, 1'b0, 1'b0, 8'd4);
    cycle(1'b0, 1'b1, 1'b0, 8'd4);
    repeat_cycle(12, 1'b0, 1'b0, 8'd4);
    // Single-cycle wake pulse, then idle through WAKE (re-sleeps after RUN).
    cycle(1'b0, 1'b1, 1'b0, 8'd4);
    repeat_cycle(10, 1'b0, 1'b0, 8'd4);
    // Guards: limit 0, then force_on, each with a long idle stretch.
    repeat_cycle(3, 1'b1, 1'b0, 8'd0);
    repeat_cycle(300, 1'b0, 1'b0, 8'd0);
    repeat_cycle(300, 1'b0, 1'b1, 8'd4);
    // Limit 0 back to 4: the count restarts, no instant sleep.
    repeat_cycle(6, 1'b0, 1'b0, 8'd4);
    // Live limit lowering below the running count.
    repeat_cycle(3, 1'b1, 1'b0, 8'd20);
    repeat_cycle(10, 1'b0, 1'b0, 8'd20);
    repeat_cycle(3, 1'b0, 1'b0, 8'd5);
    // Reset mid-WAKE.
    cycle(1'b0, 1'b1, 1'b0, 8'd5);
    cycle(1'b1, 1'b1, 1'b0, 8'd5);
    repeat_cycle(3, 1'b1, 1'b0, 8'd1);
    // Limit 1 and activity on the threshold cycle.
    repeat_cycle(4, 1'b0, 1'b0, 8'd1);
    repeat_cycle(4, 1'b1, 1'b0, 8'd1);
    // Randomized traffic.
    lim = 8'd3;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) lim = 8'($urandom_range(0, 6));
      a = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 299) == 0);
      cycle(r, a, f, lim);
    end
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
